// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Decode-stage hazard/stall controller. A shift-register scoreboard tracks
//   the instructions in flight between issue and register-file write. From
//   it the block derives the IF/ID and PC stall, optional operand forwarding
//   selects, and the halt/drain sequence started by the halt instruction.
//
// Parameters
//   INST_WIDTH        instruction width (bits [24:0] decoded)
//   PIPE_DEPTH        scoreboard slots, 1..8
//   CTRL_STALL_CYCLES stall cycles behind an issued branch/jump (<= PIPE_DEPTH)
//   LOAD_STALL_CYCLES stall cycles behind an issued load (<= PIPE_DEPTH)
//   FORWARD_EN        1 = forward non-load results instead of stalling on RAW
//   HALT_DRAIN        cycles from halt detection to halt assertion (>= 1)
//
// Ports
//   clk                 clock, rising edge
//   reset               synchronous, active-high
//   dec_inst            instruction in ID
//   dec_valid           dec_inst is real (0 = bubble)
//   ext_stall           external freeze
//   stall_id_if_pl      hold IF/ID register
//   stall_pc_increment  hold PC (same as stall_id_if_pl)
//   issue               instruction leaves ID this cycle
//   fwd_rs1_sel         0 = register file, k = result of slot k-1
//   fwd_rs2_sel         as fwd_rs1_sel, for rs2
//   halt                core halted and drained
module hazard_scoreboard #(
   parameter int unsigned INST_WIDTH        = 32,
   parameter int unsigned PIPE_DEPTH        = 2,
   parameter int unsigned CTRL_STALL_CYCLES = 2,
   parameter int unsigned LOAD_STALL_CYCLES = 2,
   parameter int unsigned FORWARD_EN        = 0,
   parameter int unsigned HALT_DRAIN        = 2,
   localparam int unsigned FWD_W            = $clog2(PIPE_DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INST_WIDTH-1:0] dec_inst,
   input  logic                  dec_valid,
   input  logic                  ext_stall,
   output logic                  stall_id_if_pl,
   output logic                  stall_pc_increment,
   output logic                  issue,
   output logic [FWD_W-1:0]      fwd_rs1_sel,
   output logic [FWD_W-1:0]      fwd_rs2_sel,
   output logic                  halt
);

   localparam int unsigned DRAIN_W = $clog2(HALT_DRAIN + 1);
   localparam logic [INST_WIDTH-1:0] HALT_INST = INST_WIDTH'(32'hC0001073);

   typedef enum logic [6:0] {
      OPC_LOAD   = 7'b0000011,
      OPC_OP_IMM = 7'b0010011,
      OPC_AUIPC  = 7'b0010111,
      OPC_STORE  = 7'b0100011,
      OPC_OP     = 7'b0110011,
      OPC_LUI    = 7'b0110111,
      OPC_BRANCH = 7'b1100011,
      OPC_JALR   = 7'b1100111,
      OPC_JAL    = 7'b1101111,
      OPC_SYSTEM = 7'b1110011
   } opcode_e;

   typedef struct packed {
      logic       valid;
      logic [4:0] rd;
      logic       is_load;
      logic       is_ctrl;
      logic       writes_rd;
   } slot_t;

   slot_t               slot_q [PIPE_DEPTH];
   slot_t               slot_d [PIPE_DEPTH];
   logic                halt_q, halt_d;
   logic [DRAIN_W-1:0]  drain_q, drain_d;

   opcode_e             opcode;
   slot_t               dec_slot;
   logic                reads_rs1, reads_rs2;
   logic [4:0]          rs1, rs2;

   logic                ctrl_hz, load_hz, raw_hz, stall;
   logic                hit1, hit2, in_load_win, found1, found2;
   logic [FWD_W-1:0]    fwd1, fwd2;

   assign opcode = opcode_e'(dec_inst[6:0]);
   assign rs1    = dec_inst[19:15];
   assign rs2    = dec_inst[24:20];

   // Decode of the ID-stage instruction into a scoreboard entry.
   always_comb begin
      dec_slot       = '0;
      reads_rs1      = 1'b0;
      reads_rs2      = 1'b0;
      dec_slot.valid = 1'b1;
      dec_slot.rd    = dec_inst[11:7];
      case (opcode)
         OPC_OP: begin
            dec_slot.writes_rd = 1'b1;
            reads_rs1          = 1'b1;
            reads_rs2          = 1'b1;
         end
         OPC_OP_IMM, OPC_SYSTEM: begin
            dec_slot.writes_rd = 1'b1;
            reads_rs1          = 1'b1;
         end
         OPC_LUI, OPC_AUIPC: begin
            dec_slot.writes_rd = 1'b1;
         end
         OPC_LOAD: begin
            dec_slot.writes_rd = 1'b1;
            dec_slot.is_load   = 1'b1;
            reads_rs1          = 1'b1;
         end
         OPC_JAL: begin
            dec_slot.writes_rd = 1'b1;
            dec_slot.is_ctrl   = 1'b1;
         end
         OPC_JALR: begin
            dec_slot.writes_rd = 1'b1;
            dec_slot.is_ctrl   = 1'b1;
            reads_rs1          = 1'b1;
         end
         OPC_BRANCH: begin
            dec_slot.is_ctrl   = 1'b1;
            reads_rs1          = 1'b1;
            reads_rs2          = 1'b1;
         end
         OPC_STORE: begin
            reads_rs1          = 1'b1;
            reads_rs2          = 1'b1;
         end
         default: ;
      endcase
      // x0 is never a real destination, so it can never create a hazard.
      if (dec_inst[11:7] == 5'd0) begin
         dec_slot.writes_rd = 1'b0;
      end
   end

   // Hazard scan. Slots are visited youngest first so the first qualifying
   // forwarding match is the one selected.
   always_comb begin
      ctrl_hz     = 1'b0;
      load_hz     = 1'b0;
      raw_hz      = 1'b0;
      hit1        = 1'b0;
      hit2        = 1'b0;
      in_load_win = 1'b0;
      found1      = 1'b0;
      found2      = 1'b0;
      fwd1        = '0;
      fwd2        = '0;
      for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
         hit1        = dec_valid && reads_rs1 && slot_q[i].valid &&
                       slot_q[i].writes_rd && (slot_q[i].rd == rs1);
         hit2        = dec_valid && reads_rs2 && slot_q[i].valid &&
                       slot_q[i].writes_rd && (slot_q[i].rd == rs2);
         in_load_win = slot_q[i].is_load && (i < LOAD_STALL_CYCLES);
         if (slot_q[i].valid && slot_q[i].is_ctrl && (i < CTRL_STALL_CYCLES)) begin
            ctrl_hz = 1'b1;
         end
         if (slot_q[i].valid && in_load_win) begin
            load_hz = 1'b1;
         end
         if ((hit1 || hit2) && ((FORWARD_EN == 0) || in_load_win)) begin
            raw_hz = 1'b1;
         end
         if (FORWARD_EN != 0) begin
            if (hit1 && !in_load_win && !found1) begin
               fwd1   = FWD_W'(i + 1);
               found1 = 1'b1;
            end
            if (hit2 && !in_load_win && !found2) begin
               fwd2   = FWD_W'(i + 1);
               found2 = 1'b1;
            end
         end
      end
   end

   assign stall              = halt_q || ext_stall || ctrl_hz || load_hz || raw_hz;
   assign stall_id_if_pl     = stall;
   assign stall_pc_increment = stall;
   assign issue              = dec_valid && !stall;
   assign fwd_rs1_sel        = fwd1;
   assign fwd_rs2_sel        = fwd2;
   assign halt               = halt_q && (drain_q == '0);

   always_comb begin
      slot_d[0] = issue ? dec_slot : '0;
      for (int unsigned i = 1; i < PIPE_DEPTH; i++) begin
         slot_d[i] = slot_q[i-1];
      end
   end

   // Drain counts down regardless of ext_stall once halt is latched.
   always_comb begin
      halt_d  = halt_q || (issue && (dec_inst == HALT_INST));
      drain_d = drain_q;
      if (halt_q && (drain_q != '0)) begin
         drain_d = drain_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
            slot_q[i] <= '0;
         end
         halt_q  <= 1'b0;
         drain_q <= DRAIN_W'(HALT_DRAIN);
      end else begin
         if (!ext_stall) begin
            for (int unsigned i = 0; i < PIPE_DEPTH; i++) begin
               slot_q[i] <= slot_d[i];
            end
         end
         halt_q  <= halt_d;
         drain_q <= drain_d;
      end
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (default stalling config and a
// forwarding config with PIPE_DEPTH=3), each compared every cycle against an
// in-bench model built from the decode/hazard rules, plus directed scenarios.
module tb_hazard_scoreboard;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] inst [2];
   logic        valid [2];
   logic        ext;
   logic        st [2], pcs [2], iss [2], hl [2];
   logic [1:0]  f1 [2], f2 [2];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   hazard_scoreboard #(
      .INST_WIDTH(32), .PIPE_DEPTH(2), .CTRL_STALL_CYCLES(2),
      .LOAD_STALL_CYCLES(2), .FORWARD_EN(0), .HALT_DRAIN(2)
   ) dut0 (
      .clk(clk), .reset(reset), .dec_inst(inst[0]), .dec_valid(valid[0]),
      .ext_stall(ext), .stall_id_if_pl(st[0]), .stall_pc_increment(pcs[0]),
      .issue(iss[0]), .fwd_rs1_sel(f1[0]), .fwd_rs2_sel(f2[0]), .halt(hl[0])
   );

   hazard_scoreboard #(
      .INST_WIDTH(32), .PIPE_DEPTH(3), .CTRL_STALL_CYCLES(2),
      .LOAD_STALL_CYCLES(2), .FORWARD_EN(1), .HALT_DRAIN(2)
   ) dut1 (
      .clk(clk), .reset(reset), .dec_inst(inst[1]), .dec_valid(valid[1]),
      .ext_stall(ext), .stall_id_if_pl(st[1]), .stall_pc_increment(pcs[1]),
      .issue(iss[1]), .fwd_rs1_sel(f1[1]), .fwd_rs2_sel(f2[1]), .halt(hl[1])
   );

   localparam logic [6:0] LOAD = 7'h03, OPIMM = 7'h13, AUIPC = 7'h17,
                          STORE = 7'h23, OP = 7'h33, LUI = 7'h37,
                          BRANCH = 7'h63, JALR = 7'h67, JAL = 7'h6f,
                          SYSTEM = 7'h73;
   localparam logic [31:0] HALT_W = 32'hC0001073;

   // ---------------- reference model ----------------
   typedef struct {
      bit       wr, ld, ctl, u1, u2;
      bit [4:0] rd, rs1, rs2;
   } dec_t;

   typedef struct {
      bit   v;
      dec_t d;
   } rec_t;

   rec_t fl [2][8];      // in-flight records, index = age in cycles
   bit   hs [2];
   int   dc [2];

   function automatic int depth_of(input int c);
      return (c == 0) ? 2 : 3;
   endfunction

   function automatic dec_t decode(input logic [31:0] w);
      dec_t d;
      d = '{default: 0};
      d.rd = w[11:7]; d.rs1 = w[19:15]; d.rs2 = w[24:20];
      case (w[6:0])
         OP:          begin d.wr = 1; d.u1 = 1; d.u2 = 1; end
         OPIMM:       begin d.wr = 1; d.u1 = 1; end
         SYSTEM:      begin d.wr = 1; d.u1 = 1; end
         LUI, AUIPC:  begin d.wr = 1; end
         LOAD:        begin d.wr = 1; d.u1 = 1; d.ld = 1; end
         JAL:         begin d.wr = 1; d.ctl = 1; end
         JALR:        begin d.wr = 1; d.u1 = 1; d.ctl = 1; end
         BRANCH:      begin d.u1 = 1; d.u2 = 1; d.ctl = 1; end
         STORE:       begin d.u1 = 1; d.u2 = 1; end
         default: ;
      endcase
      if (d.rd == 0) d.wr = 0;
      return d;
   endfunction

   function automatic void model_reset();
      for (int c = 0; c < 2; c++) begin
         for (int i = 0; i < 8; i++) fl[c][i].v = 0;
         hs[c] = 0;
         dc[c] = 2;
      end
   endfunction

   function automatic void predict(input int c, output bit s, output bit is,
                                   output bit [1:0] e1, output bit [1:0] e2,
                                   output bit h);
      dec_t d;
      bit   raw, blk, a, b, young_load;
      d   = decode(inst[c]);
      raw = 0; blk = 0; e1 = 0; e2 = 0;
      for (int i = 0; i < depth_of(c); i++) begin
         if (fl[c][i].v) begin
            young_load = fl[c][i].d.ld && (i < 2);
            if (i < 2 && (fl[c][i].d.ctl || fl[c][i].d.ld)) blk = 1;
            a = valid[c] && d.u1 && fl[c][i].d.wr && fl[c][i].d.rd == d.rs1;
            b = valid[c] && d.u2 && fl[c][i].d.wr && fl[c][i].d.rd == d.rs2;
            if (c == 0 && (a || b)) raw = 1;
            if (c == 1 && (a || b) && young_load) raw = 1;
            if (c == 1 && a && !young_load && e1 == 0) e1 = 2'(i + 1);
            if (c == 1 && b && !young_load && e2 == 0) e2 = 2'(i + 1);
         end
      end
      s  = hs[c] || ext || blk || raw;
      is = valid[c] && !s;
      h  = hs[c] && dc[c] == 0;
   endfunction

   function automatic void model_edge(input int c, input bit is);
      if (reset) begin
         for (int i = 0; i < 8; i++) fl[c][i].v = 0;
         hs[c] = 0;
         dc[c] = 2;
         return;
      end
      if (hs[c] && dc[c] != 0) dc[c]--;
      if (is && inst[c] == HALT_W) hs[c] = 1;
      if (!ext) begin
         for (int i = 7; i > 0; i--) fl[c][i] = fl[c][i-1];
         fl[c][0].v = is;
         fl[c][0].d = decode(inst[c]);
      end
   endfunction

   // ---------------- checking ----------------
   logic       dut_issue [2], dut_stall [2], dut_halt [2];
   logic [1:0] dut_f1 [2], dut_f2 [2];
   bit         exp_issue [2];

   task automatic chk(input string tag, input int c,
                      input logic [3:0] act, input logic [3:0] exp);
      checks++;
      assert (act === exp) else begin
         errors++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, c, act, exp);
      end
   endtask

   // Inputs are set just after a rising edge; outputs are sampled mid-cycle.
   task automatic tick();
      bit s, is, h;
      bit [1:0] e1, e2;
      #3;
      for (int c = 0; c < 2; c++) begin
         predict(c, s, is, e1, e2, h);
         chk("stall", c, {3'b0, st[c]}, {3'b0, s});
         chk("pc_stall", c, {3'b0, pcs[c]}, {3'b0, s});
         chk("issue", c, {3'b0, iss[c]}, {3'b0, is});
         chk("fwd1", c, {2'b0, f1[c]}, {2'b0, e1});
         chk("fwd2", c, {2'b0, f2[c]}, {2'b0, e2});
         chk("halt", c, {3'b0, hl[c]}, {3'b0, h});
         exp_issue[c] = is;
         dut_issue[c] = iss[c];
         dut_stall[c] = st[c];
         dut_halt[c]  = hl[c];
         dut_f1[c]    = f1[c];
         dut_f2[c]    = f2[c];
      end
      @(posedge clk);
      for (int c = 0; c < 2; c++) model_edge(c, exp_issue[c]);
      #1;
   endtask

   task automatic bubbles(input int n);
      valid[0] = 0; valid[1] = 0;
      repeat (n) tick();
   endtask

   // Presents w to instance c until that instance issues it (bounded).
   task automatic issue_wait(input int c, input logic [31:0] w, output int stalls,
                             output logic [1:0] g1, output logic [1:0] g2);
      bit done;
      done = 0; stalls = 0; g1 = 'x; g2 = 'x;
      inst[c] = w; valid[c] = 1;
      for (int n = 0; n < 30 && !done; n++) begin
         tick();
         if (dut_issue[c] === 1'b1) begin
            done = 1; g1 = dut_f1[c]; g2 = dut_f2[c];
         end else begin
            stalls++;
         end
      end
      chk("issue_wait", c, {3'b0, done}, 4'd1);
      valid[c] = 0;
   endtask

   function automatic logic [31:0] enc(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] r1, input logic [4:0] r2);
      return {7'd0, r2, r1, 3'd0, rd, op};
   endfunction

   initial begin
      int stalls, cnt;
      logic [1:0] g1, g2;
      logic [6:0] ops [11];
      logic [6:0] op;
      logic [31:0] w;

      ops = '{LOAD, OPIMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL, SYSTEM, 7'h0b};
      reset = 1; ext = 0;
      inst[0] = 0; inst[1] = 0; valid[0] = 0; valid[1] = 0;
      @(posedge clk); @(posedge clk); #1;
      model_reset();
      reset = 0;

      // Post-reset: outputs idle, issue follows dec_valid.
      inst[0] = enc(OPIMM, 5'd1, 5'd0, 5'd1); valid[0] = 0;
      tick();
      chk("rst_stall", 0, {3'b0, dut_stall[0]}, 4'd0);
      chk("rst_issue", 0, {3'b0, dut_issue[0]}, 4'd0);
      bubbles(1);

      // ADDI x5 then ADD x6,x5,x5 without forwarding.
      issue_wait(0, enc(OPIMM, 5'd5, 5'd0, 5'd1), stalls, g1, g2);
      chk("addi_nostall", 0, 4'(stalls), 4'd0);
      issue_wait(0, enc(OP, 5'd6, 5'd5, 5'd5), stalls, g1, g2);
      chk("raw_stall2", 0, 4'(stalls), 4'd2);
      chk("raw_fwd1_0", 0, {2'b0, g1}, 4'd0);
      chk("raw_fwd2_0", 0, {2'b0, g2}, 4'd0);

      // Same pair with forwarding.
      bubbles(4);
      issue_wait(1, enc(OPIMM, 5'd5, 5'd0, 5'd1), stalls, g1, g2);
      issue_wait(1, enc(OP, 5'd6, 5'd5, 5'd5), stalls, g1, g2);
      chk("fwd_nostall", 1, 4'(stalls), 4'd0);
      chk("fwd_rs1_1", 1, {2'b0, g1}, 4'd1);
      chk("fwd_rs2_1", 1, {2'b0, g2}, 4'd1);

      // LW x7 then ADD x8,x7,x1: load shadow then forward from slot 2.
      issue_wait(1, enc(LOAD, 5'd7, 5'd1, 5'd0), stalls, g1, g2);
      issue_wait(1, enc(OP, 5'd8, 5'd7, 5'd1), stalls, g1, g2);
      chk("ld_stall2", 1, 4'(stalls), 4'd2);
      chk("ld_fwd1_3", 1, {2'b0, g1}, 4'd3);
      chk("ld_fwd2_0", 1, {2'b0, g2}, 4'd0);

      // Branch shadow, then an x0 writer causing no RAW.
      bubbles(4);
      issue_wait(0, enc(BRANCH, 5'd0, 5'd1, 5'd2), stalls, g1, g2);
      issue_wait(0, enc(OPIMM, 5'd9, 5'd3, 5'd1), stalls, g1, g2);
      chk("ctrl_stall2", 0, 4'(stalls), 4'd2);
      bubbles(3);
      issue_wait(0, enc(OPIMM, 5'd0, 5'd1, 5'd1), stalls, g1, g2);
      issue_wait(0, enc(OP, 5'd10, 5'd0, 5'd0), stalls, g1, g2);
      chk("x0_nostall", 0, 4'(stalls), 4'd0);

      // ext_stall for 3 cycles inside a load shadow lengthens it by 3.
      bubbles(3);
      issue_wait(0, enc(LOAD, 5'd7, 5'd1, 5'd0), stalls, g1, g2);
      inst[0] = enc(OPIMM, 5'd11, 5'd1, 5'd1); valid[0] = 1; ext = 1;
      cnt = 0;
      repeat (3) begin
         tick();
         if (dut_stall[0] === 1'b1) cnt++;
      end
      ext = 0;
      issue_wait(0, enc(OPIMM, 5'd11, 5'd1, 5'd1), stalls, g1, g2);
      chk("ext_window5", 0, 4'(cnt + stalls), 4'd5);

      // Halt: stall from next cycle, halt after HALT_DRAIN edges, reset clears.
      bubbles(3);
      issue_wait(0, HALT_W, stalls, g1, g2);
      cnt = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (k == 0) chk("halt_stall", 0, {3'b0, dut_stall[0]}, 4'd1);
         if (dut_halt[0] === 1'b1) break;
         cnt++;
      end
      chk("halt_drain2", 0, 4'(cnt), 4'd2);
      reset = 1;
      tick();
      reset = 0;
      inst[0] = enc(OP, 5'd3, 5'd4, 5'd5); valid[0] = 1;
      tick();
      chk("rst_halt_clr", 0, {3'b0, dut_halt[0]}, 4'd0);
      chk("rst_stall_clr", 0, {3'b0, dut_stall[0]}, 4'd0);
      chk("rst_issue_v", 0, {3'b0, dut_issue[0]}, 4'd1);

      // Random traffic against the model.
      for (int n = 0; n < 800; n++) begin
         reset = ($urandom_range(0, 79) == 0);
         ext   = ($urandom_range(0, 9) == 0);
         op = ops[$urandom_range(0, 10)];
         w  = {7'($urandom), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               3'($urandom), 5'($urandom_range(0, 7)), op};
         if ($urandom_range(0, 149) == 0) w = HALT_W;
         for (int c = 0; c < 2; c++) begin
            inst[c]  = w;
            valid[c] = ($urandom_range(0, 99) < 85);
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the fixed two-deep decode-stage hazard/stall controller. An internal shift-register scoreboard of in-flight instructions replaces the externally supplied curr/prev instruction words. The block gates decode→fetch issue with stall outputs, optionally generates operand forwarding selects, and sequences halt/drain on the invalid (halt) instruction. It sits beside the ID stage and drives the IF/ID pipeline register and the PC-increment enable.

Parameters:
INST_WIDTH, 32, instruction word width; only bits [24:0] are decoded.
PIPE_DEPTH, 2, scoreboard slots, one per stage between issue and register-file write; range 1..8.
CTRL_STALL_CYCLES, 2, stall cycles after an issued BRANCH/JAL/JALR; must be <= PIPE_DEPTH.
LOAD_STALL_CYCLES, 2, stall cycles after an issued LOAD; must be <= PIPE_DEPTH.
FORWARD_EN, 0, 1 = forward results of non-load writers instead of stalling on RAW.
HALT_DRAIN, 2, cycles from halt detection to halt assertion; must be >= 1.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-high reset.
dec_inst  in  INST_WIDTH  instruction in the ID stage.
dec_valid  in  1  dec_inst holds a real instruction; 0 = bubble.
ext_stall  in  1  external freeze, e.g. memory wait.
stall_id_if_pl  out  1  hold the IF/ID pipeline register.
stall_pc_increment  out  1  hold the PC; always equal to stall_id_if_pl.
issue  out  1  dec_valid && !stall_id_if_pl.
fwd_rs1_sel  out  FWD_W  0 = register file; k = result of slot k-1. FWD_W = $clog2(PIPE_DEPTH+1).
fwd_rs2_sel  out  FWD_W  same encoding as fwd_rs1_sel, for rs2.
halt  out  1  core halted; pipeline drained.

Behaviour:
- Slot i (0 = youngest) holds {valid, rd[4:0], is_load, is_ctrl, writes_rd}.
- Each edge with !ext_stall:
  - slot[0] <= decoded dec_inst if issue, else a bubble (valid = 0).
  - slot[i] <= slot[i-1].
- With ext_stall = 1, all slots hold.
- Decode rules:
  - Writers: OP, OP_IMM, LUI, AUIPC, SYSTEM, LOAD, JAL, JALR. A writer with rd = x0 sets writes_rd = 0.
  - Readers of rs1 and rs2: OP, BRANCH, STORE.
  - Readers of rs1 only: OP_IMM, JALR, LOAD, SYSTEM.
  - Readers of neither: LUI, AUIPC, JAL, and unknown opcodes.
  - is_ctrl = BRANCH, JAL or JALR. is_load = LOAD.
- stall_id_if_pl is combinational: OR of the following terms.
  - halt_state.
  - ext_stall.
  - ctrl: any valid slot i < CTRL_STALL_CYCLES with is_ctrl.
  - load: any valid slot i < LOAD_STALL_CYCLES with is_load.
  - RAW: dec_valid, and some valid slot with writes_rd whose rd matches an rs that dec_inst reads.
    - FORWARD_EN = 0: any match stalls.
    - FORWARD_EN = 1: a match stalls only when the matching slot has is_load and index < LOAD_STALL_CYCLES. All other matches forward.
- Forwarding (FORWARD_EN = 1):
  - fwd_rsN_sel = k+1, where k is the lowest-index (youngest) matching valid writer slot. Load slots qualify only when index >= LOAD_STALL_CYCLES.
  - Otherwise fwd_rsN_sel = 0.
  - The select is 0 when the rs is unused, when rs = x0, or when dec_valid = 0.
  - With FORWARD_EN = 0, both selects are constant 0.
- Halt:
  - halt_state <= 1 on an edge where issue && dec_inst == 32'hC0001073. It is sticky until reset.
  - drain_cnt is reset to HALT_DRAIN. It decrements once per edge while halt_state && drain_cnt != 0 (decrement ignores ext_stall).
  - halt = halt_state && drain_cnt == 0.
- Reset values: all slots invalid, halt_state = 0, drain_cnt = HALT_DRAIN. The cycle after reset, all outputs are 0 except issue = dec_valid.
- Reset mid-operation clears the slots and the halt state on that edge, with no residual stall.
- Simultaneous events:
  - ext_stall with a hazard: stall, slots frozen.
  - Halt instruction behind a hazard: halt_state is not set until that instruction actually issues.
  - Multiple slot matches: the youngest match wins.

Test Plan:
- Defaults, issue ADDI x5,x0,1 then ADD x6,x5,x5 back-to-back -> stall asserted for 2 cycles; ADD issues on cycle 3; fwd selects = 0.
- FORWARD_EN=1, PIPE_DEPTH=3, same pair -> no stall; fwd_rs1_sel = fwd_rs2_sel = 1.
- FORWARD_EN=1, LW x7 then ADD x8,x7,x1 -> 2 stall cycles; on issue fwd_rs1_sel = 3, fwd_rs2_sel = 0.
- BEQ issued, then independent ADDI presented -> stall exactly CTRL_STALL_CYCLES cycles. Same check with ADDI x0 as writer -> no RAW stall.
- ext_stall pulsed for 3 cycles during a load shadow -> slots frozen; the stall window lengthens by 3 cycles.
- Issue 0xC0001073 -> stall from the next cycle; halt rises exactly HALT_DRAIN cycles later. reset -> halt and stall drop the next cycle.
